platform_led_scheduler: RTL
===========================

# platform_led_scheduler

Sequencer/arbiter that owns the write port of the platform LED PIO. It shares the PIO's single data register between a direct host request channel and an autonomous pattern engine (static, rotate, bounce, binary count) paced by a programmable prescaler. It sits between the CPU-side Avalon interconnect and the LED PIO slave, issuing one-cycle Avalon-MM writes to PIO address 0.

## Interface
Parameters:
- LED_WIDTH, 10, width of LED pattern and PIO data register
- PRESCALE_WIDTH, 24, width of prescaler reload and counter
- DEFAULT_PRESCALE, 24'd999_999, reset value of PRESCALE register

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- cfg_address  in  2  config register select
- cfg_chipselect  in  1  config access strobe
- cfg_write_n  in  1  active-low config write
- cfg_writedata  in  32  config write data
- cfg_readdata  out  32  config read data, combinational, zero wait
- req_valid  in  1  host direct-write request
- req_data  in  LED_WIDTH  host LED value
- req_ready  out  1  request accepted when req_valid && req_ready
- pio_address  out  2  to PIO, always 0 on writes
- pio_chipselect  out  1  to PIO
- pio_write_n  out  1  to PIO, active-low
- pio_writedata  out  32  to PIO, {zeros, value}

## Operation
- Config registers (write when cfg_chipselect && !cfg_write_n):
  - 0 CTRL: bit0 enable, bits2:1 mode (0 static, 1 rotate, 2 bounce, 3 count). Reset 0.
  - 1 PRESCALE: bits PRESCALE_WIDTH-1:0. Reset DEFAULT_PRESCALE.
  - 2 PATTERN: bits LED_WIDTH-1:0; write loads engine pattern `pat` and sets `pending`. Reset 0.
  - 3 STATUS (read): bit0 busy (FSM in WRITE), bit1 pending, bit2 overrun (sticky), bit3 dir, bits 16+LED_WIDTH-1:16 `pat`. Any write to STATUS clears overrun. Unused bits read 0.
- Prescaler: counter `pc`; enable=0 holds pc=0, no ticks. Enabled: tick when pc==PRESCALE, then pc<=0; else pc<=pc+1. PRESCALE=0 ticks every cycle. CTRL write clears pc and sets pending.
- Pattern advance on tick (mode static: no change):
  - rotate: pat <= {pat[W-2:0], pat[W-1]}.
  - bounce: dir=0: if pat[W-1] then dir<=1, pat<=pat>>1 else pat<=pat<<1; dir=1 mirrored on pat[0]. Reset dir=0.
  - rotate/bounce with pat==0: pat<=1, dir<=0.
  - count: pat<=pat+1, modulo 2^LED_WIDTH.
  - Tick in non-static mode sets pending; if pending already set, overrun<=1 (coalesced: only latest pat written).
- Same-cycle PATTERN write and tick: PATTERN write wins, tick advance dropped, pc still reloads.
- FSM: IDLE, WRITE.
  - IDLE: if req_valid -> latch req_data, WRITE (host priority). Else if pending -> latch pat, clear pending, WRITE. Else stay.
  - WRITE: pio_chipselect=1, pio_write_n=0, pio_address=0, pio_writedata=latched value, for exactly 1 cycle; -> IDLE.
  - pending set in the same cycle it is cleared (new tick/write) remains set.
- req_ready = (state==IDLE) && !reset. A pending pattern write waits while req_valid stays high (host may starve engine; overrun records it).

## Timing
- Reset (synchronous, sampled on clk edge): state IDLE, pio_chipselect 0, pio_write_n 1, pio_address 0, pio_writedata 0, pat 0, dir 0, pending 0, overrun 0, pc 0, CTRL 0, PATTERN 0, PRESCALE default. req_ready 0 while reset high. Reset mid-WRITE aborts: outputs idle next cycle.
- pio_* outputs registered; PIO write occurs on the edge following the WRITE cycle.
- Request accepted at edge N -> WRITE cycle N+1 -> PIO register updated edge N+2. Max throughput one write per 2 cycles.
- Tick at edge N -> pending at N+1 -> WRITE at N+2 (if no host request).
- cfg_readdata combinational from current register state.

## Test plan
- Reset: assert reset 2 cycles -> pio_chipselect 0, pio_write_n 1, req_ready 0; after release req_ready 1, STATUS reads 0.
- Host write: req_valid, req_data=10'h2A5 -> one WRITE cycle, pio_writedata=32'h2A5, req_ready low exactly 1 cycle.
- Rotate: PATTERN=1, PRESCALE=3, CTRL=3 (enable, rotate) -> PIO writes 1 then 2,4,8... every 4 cycles; after 10 ticks pattern wraps to 1.
- Bounce: PATTERN=10'h100, mode 2 -> writes 0x200, 0x100, 0x080; dir bit flips at 0x200 and at 0x001.
- Arbitration/overrun: PRESCALE=0, mode count, hold req_valid high 5 cycles -> only host writes during hold, STATUS.overrun=1, first engine write after release carries latest count; STATUS write clears overrun.
- Count wrap: PATTERN=10'h3FF, mode 3 -> next write 0x000.

Source files
------------

// File: rtl/platform_led_scheduler_if.sv
// Bus bundle for the LED scheduler: config slave, host request channel and PIO write port.
// The scheduler takes the slave side; the host/PIO environment takes the master side.
interface platform_led_scheduler_if #(parameter int LED_WIDTH = 10);
  logic [1:0]           cfg_address;
  logic                 cfg_chipselect;
  logic                 cfg_write_n;
  logic [31:0]          cfg_writedata;
  logic [31:0]          cfg_readdata;
  logic                 req_valid;
  logic [LED_WIDTH-1:0] req_data;
  logic                 req_ready;
  logic [1:0]           pio_address;
  logic                 pio_chipselect;
  logic                 pio_write_n;
  logic [31:0]          pio_writedata;

  modport master (
    output cfg_address, cfg_chipselect, cfg_write_n, cfg_writedata, req_valid, req_data,
    input  cfg_readdata, req_ready, pio_address, pio_chipselect, pio_write_n, pio_writedata
  );
  modport slave (
    input  cfg_address, cfg_chipselect, cfg_write_n, cfg_writedata, req_valid, req_data,
    output cfg_readdata, req_ready, pio_address, pio_chipselect, pio_write_n, pio_writedata
  );
endinterface

// File: rtl/platform_led_scheduler.sv
// Owns the LED PIO write port: arbitrates host direct writes against a prescaler-paced
// pattern engine (static/rotate/bounce/count), issuing one-cycle writes to PIO address 0.
module platform_led_scheduler #(
  parameter int                       LED_WIDTH        = 10,
  parameter int                       PRESCALE_WIDTH   = 24,
  parameter logic [PRESCALE_WIDTH-1:0] DEFAULT_PRESCALE = 24'd999_999
) (
  input logic                    clk,
  input logic                    reset,
  platform_led_scheduler_if.slave bus
);
  typedef enum logic {IDLE, WRITE} state_t;

  state_t                    state_q, state_d;
  logic                      en_q, en_d;
  logic [1:0]                mode_q, mode_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d, pc_q, pc_d;
  logic [LED_WIDTH-1:0]      patreg_q, patreg_d, pat_q, pat_d, data_q, data_d;
  logic                      dir_q, dir_d, pend_q, pend_d, ovr_q, ovr_d;
  logic                      cs_q, cs_d, wrn_q, wrn_d;
  logic                      cfg_wr, tick, pat_wr, adv;
  logic                      unused_wdata;

  assign unused_wdata = ^bus.cfg_writedata[31:PRESCALE_WIDTH];

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    presc_d  = presc_q;
    patreg_d = patreg_q;
    pat_d    = pat_q;
    dir_d    = dir_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    data_d   = data_q;
    cs_d     = 1'b0;
    wrn_d    = 1'b1;

    cfg_wr = bus.cfg_chipselect && !bus.cfg_write_n;
    tick   = en_q && (pc_q == presc_q);
    pat_wr = cfg_wr && (bus.cfg_address == 2'd2);
    // A same-cycle PATTERN write overrides the tick's advance; pc still reloads.
    adv    = tick && (mode_q != 2'd0) && !pat_wr;
    pc_d   = (!en_q || tick) ? '0 : pc_q + 1'b1;

    if (cfg_wr) begin
      case (bus.cfg_address)
        2'd0: begin
          en_d   = bus.cfg_writedata[0];
          mode_d = bus.cfg_writedata[2:1];
          pc_d   = '0;
        end
        2'd1: presc_d = bus.cfg_writedata[PRESCALE_WIDTH-1:0];
        2'd2: begin
          patreg_d = bus.cfg_writedata[LED_WIDTH-1:0];
          pat_d    = bus.cfg_writedata[LED_WIDTH-1:0];
        end
        default: ovr_d = 1'b0;
      endcase
    end

    if (adv) begin
      if (mode_q != 2'd3 && pat_q == '0) begin
        pat_d = LED_WIDTH'(1);
        dir_d = 1'b0;
      end else begin
        case (mode_q)
          2'd1: pat_d = {pat_q[LED_WIDTH-2:0], pat_q[LED_WIDTH-1]};
          2'd2: begin
            if (!dir_q) begin
              if (pat_q[LED_WIDTH-1]) begin dir_d = 1'b1; pat_d = pat_q >> 1; end
              else pat_d = pat_q << 1;
            end else begin
              if (pat_q[0]) begin dir_d = 1'b0; pat_d = pat_q << 1; end
              else pat_d = pat_q >> 1;
            end
          end
          default: pat_d = pat_q + 1'b1;
        endcase
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          data_d  = bus.req_data;
          state_d = WRITE;
        end else if (pend_q) begin
          data_d  = pat_q;
          pend_d  = 1'b0;
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == WRITE) begin
      cs_d  = 1'b1;
      wrn_d = 1'b0;
    end

    // New work arriving in the cycle the FSM consumes pending keeps it set; overrun set beats clear.
    if ((cfg_wr && (bus.cfg_address == 2'd0 || pat_wr)) || adv) pend_d = 1'b1;
    if (adv && pend_q) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'd0;
      presc_q  <= DEFAULT_PRESCALE;
      pc_q     <= '0;
      patreg_q <= '0;
      pat_q    <= '0;
      dir_q    <= 1'b0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      data_q   <= '0;
      cs_q     <= 1'b0;
      wrn_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      presc_q  <= presc_d;
      pc_q     <= pc_d;
      patreg_q <= patreg_d;
      pat_q    <= pat_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      data_q   <= data_d;
      cs_q     <= cs_d;
      wrn_q    <= wrn_d;
    end
  end

  always_comb begin
    bus.cfg_readdata = '0;
    case (bus.cfg_address)
      2'd0: bus.cfg_readdata[2:0] = {mode_q, en_q};
      2'd1: bus.cfg_readdata[PRESCALE_WIDTH-1:0] = presc_q;
      2'd2: bus.cfg_readdata[LED_WIDTH-1:0] = patreg_q;
      default: begin
        bus.cfg_readdata[3:0]             = {dir_q, ovr_q, pend_q, state_q == WRITE};
        bus.cfg_readdata[16 +: LED_WIDTH] = pat_q;
      end
    endcase
  end

  assign bus.req_ready      = (state_q == IDLE) && !reset;
  assign bus.pio_address    = 2'd0;
  assign bus.pio_chipselect = cs_q;
  assign bus.pio_write_n    = wrn_q;
  assign bus.pio_writedata  = {{(32-LED_WIDTH){1'b0}}, data_q};
endmodule
